mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters: the IF-stage fetch port and the MEM-stage load/store port.
- Uses a registered req/gnt/rvalid protocol on the memory side and allows one outstanding transaction.
- Arbitration is data-priority with a fetch anti-starvation counter.
- Generates stall_if_o for the fetch stage and supports fetch kill on branch-taken redirect.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_LIMIT, 4, number of consecutive fetch-losing conflicts before fetch is forced to win. Legal range 1..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- if_req_i  input  1  fetch request; held with if_addr_i stable until if_gnt_o
- if_addr_i  input  ADDR_W  fetch address
- if_kill_i  input  1  discard the in-flight fetch (branch redirect)
- if_gnt_o  output  1  fetch request accepted by memory
- if_rvalid_o  output  1  fetch data valid
- if_rdata_o  output  DATA_W  fetch data
- d_req_i  input  1  data request; held with payload stable until d_gnt_o
- d_we_i  input  1  1 = store
- d_be_i  input  DATA_W/8  byte enables
- d_addr_i  input  ADDR_W  data address
- d_wdata_i  input  DATA_W  store data
- d_gnt_o  output  1  data request accepted
- d_rvalid_o  output  1  load data valid, or store acknowledge
- d_rdata_o  output  DATA_W  load data
- mem_req_o  output  1  memory request (registered)
- mem_we_o  output  1  memory write enable (registered)
- mem_be_o  output  DATA_W/8  memory byte enables (registered)
- mem_addr_o  output  ADDR_W  memory address (registered)
- mem_wdata_o  output  DATA_W  memory write data (registered)
- mem_gnt_i  input  1  memory accepts the request
- mem_rvalid_i  input  1  memory response; also returned for writes
- mem_rdata_i  input  DATA_W  memory read data
- stall_if_o  output  1  stall request to the fetch stage
- busy_o  output  1  state != IDLE

Behaviour:
- Reset:
  - rst_n is a synchronous, active-low reset; clk is the clock.
  - On reset: state=IDLE, owner=DATA, kill_q=0, starve_cnt=0, mem_req_o=0, all mem_* payload regs=0.
  - All gnt/rvalid outputs are 0 and rdata outputs are 0 during reset.
  - Reset mid-transaction abandons the transaction. A late mem_rvalid_i is ignored because IDLE ignores mem_rvalid_i.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - No request: stay in IDLE.
  - If any request is present, select an owner, latch its payload into mem_* and set mem_req_o=1 on the next edge; next state is REQ.
  - Fetch payload: we=0, be=all ones, wdata=0.
- Owner selection in IDLE:
  - Only one request present: that requester wins.
  - Both present: DATA wins unless starve_cnt==STARVE_LIMIT, in which case IF wins.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) when DATA wins while if_req_i=1.
  - It clears to 0 whenever IF wins.
  - It holds otherwise.
- REQ:
  - mem_req_o=1 and the payload holds.
  - Owner gnt_o = mem_gnt_i, driven combinationally. For IF this is additionally gated by ~kill_q & ~if_kill_i.
  - On mem_gnt_i, mem_req_o drops at the next edge and the FSM goes to RESP.
- RESP:
  - On mem_rvalid_i, owner rvalid_o=1 and owner rdata_o=mem_rdata_i, both combinational. For IF this is gated by ~kill_q & ~if_kill_i.
  - Next state is IDLE.
  - There is a mandatory single idle cycle between transactions; no back-to-back arbitration.
- Non-owner outputs: gnt/rvalid are 0 and rdata is 0 at all times.
- Memory protocol: mem_rvalid_i arrives no earlier than the cycle after mem_gnt_i. mem_rvalid_i while in IDLE or REQ is ignored.
- Kill:
  - if_kill_i=1 while owner=IF in REQ or RESP sets kill_q.
  - The memory transaction still completes, but its if_gnt_o and if_rvalid_o are suppressed.
  - kill_q clears on entry to IDLE.
  - if_kill_i in IDLE, or with owner=DATA, has no effect.
  - A killed fetch still counts as an IF win for the starvation counter.
- stall_if_o = if_req_i & ~if_rvalid_o.
- Simultaneous d_req_i and if_kill_i in IDLE: arbitrate normally, since kill is ignored in IDLE.

Test Plan:
- Reset, then if_req_i=1 at addr 0x100 with mem_gnt_i the cycle after mem_req_o and mem_rvalid_i two cycles later carrying 0x00000013 -> mem_addr_o=0x100, if_gnt_o pulses 1 cycle, if_rvalid_o=1 with if_rdata_o=0x13, stall_if_o low only in the rvalid cycle.
- if_req_i and d_req_i (store to 0x2000, wdata 0xDEADBEEF, be 0xF) asserted together -> data served first with mem_we_o=1; fetch served in the next arbitration; starve_cnt goes 1 then 0.
- d_req_i held continuously with if_req_i, STARVE_LIMIT=4 -> four data transactions, then the fifth arbitration goes to IF; starve_cnt returns to 0.
- Fetch in RESP when if_kill_i pulses, then mem_rvalid_i arrives -> if_rvalid_o stays 0 and the FSM returns to IDLE; a new fetch at the branch target 0x40 proceeds normally.
- rst_n low while in RESP, then mem_rvalid_i arrives after reset -> state=IDLE, mem_req_o=0, no rvalid outputs, busy_o=0.
- mem_gnt_i stalled for 5 cycles in REQ with the data owner -> mem_* stays stable, d_gnt_o stays 0 until mem_gnt_i rises, and no owner switch occurs.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_kill_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [DATA_W/8-1:0] d_be_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W/8-1:0] mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_if_o;
  logic              busy_o;
  modport slave (
    input  if_req_i, if_addr_i, if_kill_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, stall_if_o, busy_o
  );
  modport master (
    output if_req_i, if_addr_i, if_kill_i, d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o, d_rvalid_o, d_rdata_o,
           mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, stall_if_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store, data priority with fetch anti-starvation
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t     state;
  logic       owner_if, kill_q, pick_if, if_ok, d_ok;
  logic [3:0] starve_cnt;
  always_comb begin
    pick_if         = bus.if_req_i & (~bus.d_req_i | (starve_cnt == LIM));
    if_ok           = rst_n & owner_if & ~kill_q & ~bus.if_kill_i;
    d_ok            = rst_n & ~owner_if;
    bus.if_gnt_o    = if_ok & (state == REQ) & bus.mem_gnt_i;
    bus.d_gnt_o     = d_ok & (state == REQ) & bus.mem_gnt_i;
    bus.if_rvalid_o = if_ok & (state == RESP) & bus.mem_rvalid_i;
    bus.d_rvalid_o  = d_ok & (state == RESP) & bus.mem_rvalid_i;
    bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : '0;
    bus.d_rdata_o   = bus.d_rvalid_o ? bus.mem_rdata_i : '0;
    bus.stall_if_o  = bus.if_req_i & ~bus.if_rvalid_o;
    bus.busy_o      = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      owner_if        <= 1'b0;
      kill_q          <= 1'b0;
      starve_cnt      <= '0;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_be_o    <= '0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: if (bus.if_req_i | bus.d_req_i) begin
          state           <= REQ;
          owner_if        <= pick_if;
          bus.mem_req_o   <= 1'b1;
          bus.mem_we_o    <= ~pick_if & bus.d_we_i;
          bus.mem_be_o    <= pick_if ? '1 : bus.d_be_i;
          bus.mem_addr_o  <= pick_if ? bus.if_addr_i : bus.d_addr_i;
          bus.mem_wdata_o <= pick_if ? '0 : bus.d_wdata_i;
          starve_cnt      <= pick_if ? '0 :
                             (bus.if_req_i && starve_cnt != LIM) ? starve_cnt + 4'd1 : starve_cnt;
        end
        REQ: begin
          if (owner_if & bus.if_kill_i) kill_q <= 1'b1;
          if (bus.mem_gnt_i) begin
            state         <= RESP;
            bus.mem_req_o <= 1'b0;
          end
        end
        RESP: begin
          // a killed fetch stays suppressed until the response drains, then clears for the next owner
          kill_q <= ~bus.mem_rvalid_i & (kill_q | (owner_if & bus.if_kill_i));
          if (bus.mem_rvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions checked against a transaction-level arbitration model
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, LIM = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, failures = 0, starve = 0;
  bit last_w_if;
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic new_if();
    bus.if_req_i  = ($urandom % 4) != 0;
    bus.if_addr_i = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_d();
    bus.d_req_i   = 1'($urandom % 2);
    bus.d_we_i    = 1'($urandom % 2);
    bus.d_be_i    = 4'($urandom);
    bus.d_addr_i  = $urandom;
    bus.d_wdata_i = $urandom;
  endtask

  // One arbitration from the idle cycle to the response; gd/rd are grant/response wait cycles,
  // kc is the cycle (counted from the first REQ cycle) at which if_kill_i pulses, -1 for none.
  task automatic txn(input int gd, input int rd, input int kc);
    bit w_if, killed, eiv, edv;
    logic [3:0] e_be;
    logic [31:0] e_addr, e_wdata, rdata;
    logic e_we;
    int k;
    w_if    = (bus.if_req_i && bus.d_req_i) ? (starve == LIM) : bus.if_req_i;
    e_we    = w_if ? 1'b0 : bus.d_we_i;
    e_be    = w_if ? 4'hF : bus.d_be_i;
    e_addr  = w_if ? bus.if_addr_i : bus.d_addr_i;
    e_wdata = w_if ? 32'h0 : bus.d_wdata_i;
    bus.if_kill_i = ($urandom % 4) == 0;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy_o), 64'(0));
    chk("idle_mem_req", 64'(bus.mem_req_o), 64'(0));
    chk("idle_stall", 64'(bus.stall_if_o), 64'(bus.if_req_i));
    if (w_if) starve = 0;
    else if (bus.if_req_i && starve < LIM) starve++;
    last_w_if = w_if;
    next();
    killed = 0;
    k = 0;
    for (int i = 0; i <= gd; i++) begin
      bus.mem_gnt_i = (i == gd);
      bus.if_kill_i = (k == kc);
      if (w_if && k == kc) killed = 1;
      @(negedge clk);
      chk("req_mem_req", 64'(bus.mem_req_o), 64'(1));
      chk("req_busy", 64'(bus.busy_o), 64'(1));
      chk("req_addr", 64'(bus.mem_addr_o), 64'(e_addr));
      chk("req_we", 64'(bus.mem_we_o), 64'(e_we));
      chk("req_be", 64'(bus.mem_be_o), 64'(e_be));
      chk("req_wdata", 64'(bus.mem_wdata_o), 64'(e_wdata));
      chk("req_if_gnt", 64'(bus.if_gnt_o), 64'((i == gd) && w_if && !killed));
      chk("req_d_gnt", 64'(bus.d_gnt_o), 64'((i == gd) && !w_if));
      chk("req_rvalid", 64'({bus.if_rvalid_o, bus.d_rvalid_o}), 64'(0));
      chk("req_stall", 64'(bus.stall_if_o), 64'(bus.if_req_i));
      next();
      k++;
    end
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i <= rd; i++) begin
      rdata = $urandom;
      bus.mem_rvalid_i = (i == rd);
      bus.mem_rdata_i  = rdata;
      bus.if_kill_i    = (k == kc);
      if (w_if && k == kc) killed = 1;
      eiv = (i == rd) && w_if && !killed;
      edv = (i == rd) && !w_if;
      @(negedge clk);
      chk("resp_mem_req", 64'(bus.mem_req_o), 64'(0));
      chk("resp_busy", 64'(bus.busy_o), 64'(1));
      chk("resp_gnt", 64'({bus.if_gnt_o, bus.d_gnt_o}), 64'(0));
      chk("resp_if_rvalid", 64'(bus.if_rvalid_o), 64'(eiv));
      chk("resp_if_rdata", 64'(bus.if_rdata_o), eiv ? 64'(rdata) : 64'(0));
      chk("resp_d_rvalid", 64'(bus.d_rvalid_o), 64'(edv));
      chk("resp_d_rdata", 64'(bus.d_rdata_o), edv ? 64'(rdata) : 64'(0));
      chk("resp_stall", 64'(bus.stall_if_o), 64'(bus.if_req_i & ~eiv));
      next();
      k++;
    end
    bus.mem_rvalid_i = 1'b0;
    bus.if_kill_i    = 1'b0;
  endtask

  initial begin
    int gd, rd, kc;
    bus.if_req_i = 0; bus.if_addr_i = 0; bus.if_kill_i = 0;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_be_i = 0; bus.d_addr_i = 0; bus.d_wdata_i = 0;
    bus.mem_gnt_i = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hFFFF_FFFF;
    next();
    next();
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy_o), 64'(0));
    chk("rst_mem_req", 64'(bus.mem_req_o), 64'(0));
    chk("rst_payload", {bus.mem_addr_o, bus.mem_wdata_o}, 64'(0));
    chk("rst_we_be", 64'({bus.mem_we_o, bus.mem_be_o}), 64'(0));
    chk("rst_gnt_rvalid", 64'({bus.if_gnt_o, bus.d_gnt_o, bus.if_rvalid_o, bus.d_rvalid_o}), 64'(0));
    chk("rst_rdata", {bus.if_rdata_o, bus.d_rdata_o}, 64'(0));
    next();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
    rst_n = 1;
    // fetch at 0x100, grant one cycle after mem_req, response two cycles after that
    bus.if_req_i = 1; bus.if_addr_i = 32'h100;
    txn(1, 1, -1);
    // store and fetch together: store first, fetch next
    bus.if_addr_i = 32'h104;
    bus.d_req_i = 1; bus.d_we_i = 1; bus.d_be_i = 4'hF; bus.d_addr_i = 32'h2000; bus.d_wdata_i = 32'hDEAD_BEEF;
    txn(0, 0, -1);
    bus.d_req_i = 0;
    txn(0, 0, -1);
    // continuous data pressure: four data wins then fetch forced through
    bus.d_req_i = 1;
    for (int n = 0; n < 5; n++) begin
      txn(0, 1, -1);
      bus.d_we_i = 1'($urandom % 2); bus.d_addr_i = $urandom; bus.d_wdata_i = $urandom; bus.d_be_i = 4'($urandom);
    end
    bus.d_req_i = 0;
    // fetch killed in RESP, then redirected fetch at 0x40
    bus.if_addr_i = 32'h80;
    txn(0, 2, 2);
    bus.if_addr_i = 32'h40;
    txn(0, 1, -1);
    // data owner waits five cycles for the grant while fetch is pending
    bus.d_req_i = 1; bus.d_we_i = 0; bus.d_addr_i = 32'h3000; bus.d_be_i = 4'h3;
    txn(5, 0, -1);
    bus.d_req_i = 0;
    txn(0, 0, -1);
    // reset in RESP, response arrives after reset
    bus.if_addr_i = 32'h200;
    next();
    bus.mem_gnt_i = 1;
    next();
    bus.mem_gnt_i = 0; rst_n = 0;
    next();
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1234;
    @(negedge clk);
    chk("rstmid_rvalid", 64'({bus.if_rvalid_o, bus.d_rvalid_o}), 64'(0));
    chk("rstmid_busy", 64'(bus.busy_o), 64'(0));
    next();
    rst_n = 1; bus.if_req_i = 0;
    @(negedge clk);
    chk("late_rvalid", 64'({bus.if_rvalid_o, bus.d_rvalid_o}), 64'(0));
    chk("late_busy", 64'(bus.busy_o), 64'(0));
    chk("late_mem_req", 64'(bus.mem_req_o), 64'(0));
    chk("late_addr", 64'(bus.mem_addr_o), 64'(0));
    next();
    bus.mem_rvalid_i = 0;
    starve = 0;
    @(negedge clk);
    chk("late_idle", 64'(bus.busy_o), 64'(0));
    next();
    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      if (!(bus.if_req_i | bus.d_req_i)) begin
        new_if();
        new_d();
      end
      if (!(bus.if_req_i | bus.d_req_i)) begin
        bus.if_kill_i = 1'($urandom % 2);
        @(negedge clk);
        chk("rnd_idle_busy", 64'(bus.busy_o), 64'(0));
        chk("rnd_idle_req", 64'(bus.mem_req_o), 64'(0));
        chk("rnd_idle_gnt", 64'({bus.if_gnt_o, bus.d_gnt_o}), 64'(0));
        next();
        bus.if_kill_i = 0;
      end else begin
        gd = $urandom_range(0, 3);
        rd = $urandom_range(0, 3);
        kc = ($urandom % 3 == 0) ? int'($urandom_range(0, gd + rd + 1)) : -1;
        txn(gd, rd, kc);
        if (last_w_if) new_if();
        else new_d();
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
